// File: rtl/fir_mac_sched.sv
// fir_mac_sched
//   Round-robin scheduler that time-shares one complex MAC datapath between
//   NUM_REQ FIR engines. It grants the MAC to one engine per job, steps tap
//   indices into the MAC, flags the first and last beats, waits out the MAC
//   pipeline, and then pulses completion back to the engine that owns the job.
//
// Ports
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous reset, active low
//   req           in   [NUM_REQ]        level request per engine
//   req_taps      in   [NUM_REQ*TAP_W]  packed job length per engine
//   gnt           out  [NUM_REQ]        one-hot grant, held for the whole job
//   gnt_id        out  [ID_W]           index of the granted engine
//   busy          out                   a job is in progress
//   mac_valid     out                   tap beat presented to the MAC
//   mac_ready     in                    MAC accepts the beat
//   mac_tap       out  [TAP_W]          tap index of the current beat
//   mac_first     out                   current beat is tap 0
//   mac_last      out                   current beat is tap len-1
//   result_valid  out                   1-cycle pulse: final MAC sum available
//   done          out  [NUM_REQ]        1-cycle one-hot completion pulse
module fir_mac_sched #(
    parameter int NUM_REQ  = 4,
    parameter int TAP_W    = 7,
    parameter int MAX_TAPS = 64,
    parameter int PIPE_LAT = 3,
    parameter int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*TAP_W-1:0] req_taps,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [ID_W-1:0]          gnt_id,
    output logic                     busy,
    output logic                     mac_valid,
    input  logic                     mac_ready,
    output logic [TAP_W-1:0]         mac_tap,
    output logic                     mac_first,
    output logic                     mac_last,
    output logic                     result_valid,
    output logic [NUM_REQ-1:0]       done
);

    localparam int DC_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [TAP_W-1:0] MAX_LEN = TAP_W'(MAX_TAPS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [TAP_W-1:0] len_q, len_d;
    logic [TAP_W-1:0] cnt_q, cnt_d;
    logic [DC_W-1:0]  dcnt_q, dcnt_d;

    // Round-robin search: first requester at or above ptr, wrapping around.
    logic             win_found;
    logic [ID_W-1:0]  win_id;
    logic [ID_W-1:0]  win_next;
    logic [TAP_W-1:0] win_taps;
    logic [TAP_W-1:0] win_len;

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int idx;
            idx = (int'(ptr_q) + i) % NUM_REQ;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
        win_next = ID_W'((int'(win_id) + 1) % NUM_REQ);
        win_taps = req_taps[int'(win_id)*TAP_W +: TAP_W];
        win_len  = (win_taps > MAX_LEN) ? MAX_LEN : win_taps;
    end

    // The owner dropping its request while the MAC is still working cancels the job.
    logic owner_req;
    assign owner_req = req[gnt_id_q];

    always_comb begin
        state_d  = state_q;
        gnt_id_d = gnt_id_q;
        ptr_d    = ptr_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        dcnt_d   = dcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    gnt_id_d = win_id;
                    ptr_d    = win_next;
                    len_d    = win_len;
                    cnt_d    = '0;
                    state_d  = (win_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (!owner_req) begin
                    state_d = S_IDLE;
                end else if (mac_ready) begin
                    cnt_d = cnt_q + TAP_W'(1);
                    if (cnt_q == len_q - TAP_W'(1)) begin
                        if (PIPE_LAT > 0) begin
                            state_d = S_DRAIN;
                            dcnt_d  = DC_W'(PIPE_LAT - 1);
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (!owner_req) begin
                    state_d = S_IDLE;
                end else if (dcnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    dcnt_d = dcnt_q - DC_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            gnt_id_q <= '0;
            ptr_q    <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            dcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            gnt_id_q <= gnt_id_d;
            ptr_q    <= ptr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            dcnt_q   <= dcnt_d;
        end
    end

    // All outputs decode flop state only, so they change on clock edges and
    // clear immediately on asynchronous reset.
    logic             in_run;
    logic             in_done;
    logic [NUM_REQ-1:0] owner_onehot;

    assign in_run       = (state_q == S_RUN);
    assign in_done      = (state_q == S_DONE);
    assign busy         = (state_q != S_IDLE);
    assign owner_onehot = NUM_REQ'(1) << gnt_id_q;

    assign gnt          = busy ? owner_onehot : '0;
    assign gnt_id       = busy ? gnt_id_q : '0;
    assign mac_valid    = in_run;
    assign mac_tap      = in_run ? cnt_q : '0;
    assign mac_first    = in_run && (cnt_q == '0);
    assign mac_last     = in_run && (cnt_q == len_q - TAP_W'(1));
    // A zero-length job never touched the MAC, so there is no sum to report.
    assign result_valid = in_done && (len_q != '0);
    assign done         = in_done ? owner_onehot : '0;

endmodule
